// File: rtl/twi_target_if.sv
// Bus and fabric signals of the TWI target, bundled for port connection.
// slave: the target's view. master: the bus controller / fabric view.
interface twi_target_if;
    logic       scl;
    logic       sdaIn;
    logic       sdaLow;
    logic [7:0] rxData;
    logic       rxValid;
    logic [7:0] txData;
    logic       txReq;
    logic       busy;

    modport slave (
        input  scl,
        input  sdaIn,
        input  txData,
        output sdaLow,
        output rxData,
        output rxValid,
        output txReq,
        output busy
    );

    modport master (
        output scl,
        output sdaIn,
        output txData,
        input  sdaLow,
        input  rxData,
        input  rxValid,
        input  txReq,
        input  busy
    );
endinterface

// File: rtl/twi_target.sv
// I2C target for a single 7-bit address. Oversamples SCL/SDA on clk, ACKs every
// byte addressed to it, hands written bytes to the fabric and fetches read bytes.
// SDA is only ever pulled low; SCL is never driven.
module twi_target #(
    parameter logic [6:0] ADDRESS = 7'h42
) (
    input logic        clk,
    input logic        reset,
    twi_target_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StReadAck, StIgnore
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic       scl_cur, sda_cur;
    logic       scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;      // first seven bits of the byte in flight
    logic [6:0] tx_shift;   // bits still to send after the MSB
    logic       rw;
    logic       ack_phase;  // ACK states: 0 = before ACK clock, 1 = inside it
    logic       sda_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;

    // Two-flop synchronizers plus a previous-sample register for edge detection.
    // Idle-high reset values keep reset release from looking like a bus event.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl};
            sda_sync <= {sda_sync[0], bus.sdaIn};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl_cur  = scl_sync[1];
    assign sda_cur  = sda_sync[1];
    assign scl_rise = ~scl_prev & scl_cur;
    assign scl_fall = scl_prev & ~scl_cur;
    assign start_ev = scl_cur & sda_prev & ~sda_cur;
    assign stop_ev  = scl_cur & ~sda_prev & sda_cur;

    // Protocol FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
            tx_shift  <= 7'd0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            sda_low   <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start_ev) begin
                state   <= StAddr;
                bit_cnt <= 3'd0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_ev) begin
                state   <= StIdle;
                bit_cnt <= 3'd0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: ;
                    StAddr: begin
                        if (scl_rise) begin
                            shift   <= {shift[5:0], sda_cur};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift == ADDRESS) begin
                                    rw        <= sda_cur;
                                    busy      <= 1'b1;
                                    ack_phase <= 1'b0;
                                    state     <= StAddrAck;
                                end else begin
                                    state <= StIgnore;
                                end
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_low   <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                                if (rw) begin
                                    tx_shift <= bus.txData[6:0];
                                    tx_req   <= 1'b1;
                                    sda_low  <= ~bus.txData[7];
                                    state    <= StRead;
                                end else begin
                                    sda_low <= 1'b0;
                                    state   <= StWrite;
                                end
                            end
                        end
                    end
                    StWrite: begin
                        if (scl_rise) begin
                            shift   <= {shift[5:0], sda_cur};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {shift, sda_cur};
                                rx_valid  <= 1'b1;
                                ack_phase <= 1'b0;
                                state     <= StWriteAck;
                            end
                        end
                    end
                    StWriteAck: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_low   <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_low   <= 1'b0;
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                                state     <= StWrite;
                            end
                        end
                    end
                    StRead: begin
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                sda_low   <= 1'b0;
                                ack_phase <= 1'b0;
                                state     <= StReadAck;
                            end else begin
                                tx_shift <= {tx_shift[5:0], 1'b0};
                                sda_low  <= ~tx_shift[6];
                            end
                        end
                    end
                    StReadAck: begin
                        if (!ack_phase) begin
                            if (scl_rise) begin
                                if (sda_cur) begin
                                    busy  <= 1'b0;
                                    state <= StIgnore;
                                end else begin
                                    ack_phase <= 1'b1;
                                end
                            end
                        end else if (scl_fall) begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= 3'd0;
                            tx_shift  <= bus.txData[6:0];
                            tx_req    <= 1'b1;
                            sda_low   <= ~bus.txData[7];
                            state     <= StRead;
                        end
                    end
                    StIgnore: sda_low <= 1'b0;
                    default:  state <= StIdle;
                endcase
            end
        end
    end

    assign bus.sdaLow  = sda_low;
    assign bus.rxData  = rx_data;
    assign bus.rxValid = rx_valid;
    assign bus.txReq   = tx_req;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_twi_target.sv
// Directed bench for twi_target: a bit-banged I2C controller plus a
// transaction-level expectation model checked by a per-cycle monitor.
module tb_twi_target;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int         Q    = 8;   // clk cycles per SCL quarter

    logic clk = 1'b0;
    logic reset;
    logic scl_m, sda_m;

    twi_target_if bus ();

    twi_target #(.ADDRESS(ADDR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Wired-AND open-drain SDA.
    assign bus.scl   = scl_m;
    assign bus.sdaIn = sda_m & ~bus.sdaLow;

    always #5 clk = ~clk;

    int         vecs = 0;
    int         miscompares = 0;
    logic [7:0] rx_exp[$];      // bytes the fabric must see, in order
    int         rx_seen = 0;
    int         tx_exp_total = 0;
    int         tx_seen = 0;
    logic       must_release;   // model: target may not pull SDA now

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL clock: data set while low, sampled mid-high, ends just after the fall.
    task automatic put_bit(input logic b, output logic r);
        wait_clk(4);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        r = bus.sdaIn;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic do_start();
        must_release = 1'b1;
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic do_stop();
        must_release = 1'b1;
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic r;
        must_release = 1'b1;
        for (int i = 7; i >= 0; i--) put_bit(b[i], r);
        must_release = ~exp_ack;
        put_bit(1'b1, r);
        chk(name, {7'd0, r}, {7'd0, ~exp_ack});
    endtask

    // Model: the target answers only when the upper seven bits equal its address.
    task automatic addr_byte(input logic [7:0] b);
        logic match;
        match = (b[7:1] == ADDR);
        if (match && b[0]) tx_exp_total++;
        wr_byte(b, match, "addr_ack");
        chk("busy_after_addr", {7'd0, bus.busy}, {7'd0, match});
    endtask

    task automatic data_byte(input logic [7:0] b);
        rx_exp.push_back(b);
        wr_byte(b, 1'b1, "data_ack");
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic ack, input logic [7:0] next_tx);
        logic       r;
        logic [7:0] d;
        d = 8'd0;
        must_release = 1'b0;
        for (int i = 0; i < 8; i++) begin
            put_bit(1'b1, r);
            d = {d[6:0], r};
            if (i == 0) bus.txData = ~exp;  // transmitted byte must already be latched
        end
        chk("read_byte", d, exp);
        must_release = 1'b1;
        if (!ack) begin
            tx_exp_total++;
            bus.txData = next_tx;
        end
        put_bit(ack, r);
        if (ack) chk("busy_after_nack", {7'd0, bus.busy}, 8'd0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.rxValid || bus.txReq)
                    chk("rx_tx_exclusive", {7'd0, bus.rxValid & bus.txReq}, 8'd0);
                if (bus.rxValid) begin
                    chk("rxValid_expected", {7'd0, rx_seen < rx_exp.size()}, 8'd1);
                    if (rx_seen < rx_exp.size()) chk("rxData", bus.rxData, rx_exp[rx_seen]);
                    rx_seen++;
                end
                if (bus.txReq) begin
                    chk("txReq_expected", {7'd0, tx_seen < tx_exp_total}, 8'd1);
                    tx_seen++;
                end
                if (must_release && scl_m)
                    chk("sda_released", {7'd0, bus.sdaLow}, 8'd0);
            end
        end
    endtask

    initial begin
        logic r;
        fork
            monitor();
        join_none

        reset        = 1'b1;
        scl_m        = 1'b1;
        sda_m        = 1'b1;
        must_release = 1'b1;
        bus.txData   = 8'h00;
        wait_clk(4);
        chk("reset_sdaLow", {7'd0, bus.sdaLow}, 8'd0);
        chk("reset_rxData", bus.rxData, 8'h00);
        chk("reset_rxValid", {7'd0, bus.rxValid}, 8'd0);
        chk("reset_txReq", {7'd0, bus.txReq}, 8'd0);
        chk("reset_busy", {7'd0, bus.busy}, 8'd0);
        reset = 1'b0;
        wait_clk(4);

        // Write two bytes.
        do_start();
        addr_byte(8'h84);
        data_byte(8'hA5);
        data_byte(8'h3C);
        do_stop();
        wait_clk(8);
        chk("write_busy_after_stop", {7'd0, bus.busy}, 8'd0);
        chk("write_rxData_last", bus.rxData, 8'h3C);
        chk("write_rx_count", rx_seen[7:0], 8'd2);

        // Wrong address: nothing driven, nothing delivered.
        do_start();
        addr_byte(8'h86);
        wr_byte(8'h11, 1'b0, "ignored_ack");
        do_stop();
        wait_clk(8);
        chk("wrongaddr_busy", {7'd0, bus.busy}, 8'd0);
        chk("wrongaddr_rx_count", rx_seen[7:0], 8'd2);

        // Read two bytes, ACK then NACK.
        bus.txData = 8'h5A;
        do_start();
        addr_byte(8'h85);
        rd_byte(8'h5A, 1'b0, 8'hC3);
        rd_byte(8'hC3, 1'b1, 8'h00);
        do_stop();
        wait_clk(8);
        chk("read_txReq_count", tx_seen[7:0], 8'd2);

        // Write, repeated START, then a one-byte read.
        do_start();
        addr_byte(8'h84);
        data_byte(8'h10);
        bus.txData = 8'h77;
        do_start();
        addr_byte(8'h85);
        rd_byte(8'h77, 1'b1, 8'h00);
        do_stop();
        wait_clk(8);
        chk("rstart_rxData", bus.rxData, 8'h10);

        // Abort mid-byte: no delivery, then target must be idle (ignores bits without START).
        do_start();
        addr_byte(8'h84);
        must_release = 1'b1;
        put_bit(1'b1, r);
        put_bit(1'b0, r);
        put_bit(1'b1, r);
        put_bit(1'b1, r);
        do_stop();
        wait_clk(8);
        chk("abort_rx_count", rx_seen[7:0], 8'd4 - 8'd1);
        chk("abort_sdaLow", {7'd0, bus.sdaLow}, 8'd0);
        chk("abort_busy", {7'd0, bus.busy}, 8'd0);
        scl_m = 1'b0;
        wait_clk(Q);
        wr_byte(8'h84, 1'b0, "idle_no_ack");
        do_stop();

        // Reset while the target pulls SDA during a read bit.
        bus.txData = 8'h00;
        do_start();
        addr_byte(8'h85);
        must_release = 1'b0;
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2);
        chk("pre_reset_sdaLow", {7'd0, bus.sdaLow}, 8'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_sdaLow", {7'd0, bus.sdaLow}, 8'd0);
        chk("post_reset_busy", {7'd0, bus.busy}, 8'd0);
        reset = 1'b0;
        must_release = 1'b1;
        wait_clk(Q);
        scl_m = 1'b0;
        do_start();
        addr_byte(8'h84);
        data_byte(8'h01);
        do_stop();
        wait_clk(8);
        chk("after_reset_rxData", bus.rxData, 8'h01);

        chk("rx_total", rx_seen[7:0], rx_exp.size() & 8'hFF);
        chk("rx_total_lit", rx_seen[7:0], 8'd4);
        chk("tx_total", tx_seen[7:0], tx_exp_total[7:0]);
        chk("tx_total_lit", tx_seen[7:0], 8'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
